// File: rtl/aqua_dispense_scheduler.sv
// Round-robin scheduler that shares one pump/manifold between NREQ water kiosks.
// It grants one kiosk, primes the valve, runs the pump to the ordered volume and reports the outcome.
module aqua_dispense_scheduler #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned PULSES_PER_L = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] vol_sel,
  input  logic            flow_pulse,
  input  logic            tank_low,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] valve_sel,
  output logic            pump_on,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] fault,
  output logic            busy,
  output logic [3:0]      litres_out
);

  localparam int unsigned      IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned      TW      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TGT_5L  = CNT_W'(5 * PULSES_PER_L);
  localparam logic [CNT_W-1:0] TGT_10L = CNT_W'(10 * PULSES_PER_L);
  localparam logic [CNT_W-1:0] PPL_M1  = CNT_W'(PULSES_PER_L - 1);
  localparam logic [TW-1:0]    TO_M1   = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0]    LAST    = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, CLOSE} state_t;
  typedef enum logic [1:0] {EX_DONE, EX_FAULT, EX_ABORT} exit_t;

  state_t            state, state_n;
  exit_t             reason, reason_n;
  logic [IW-1:0]     rr_ptr, rr_n;
  logic [IW-1:0]     idx, idx_n;
  logic              vol, vol_n;
  logic [CNT_W-1:0]  pulse_cnt, pulse_n;
  logic [CNT_W-1:0]  pl_cnt, pl_n;
  logic [TW-1:0]     to_cnt, to_n;
  logic [3:0]        litres_n;
  logic [NREQ-1:0]   grant_n, valve_n, done_n, fault_n;
  logic              pump_n, busy_n;

  logic              any_req;
  logic [IW-1:0]     win;
  int unsigned       j;
  logic [CNT_W-1:0]  target;
  logic              hit;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    j       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(rr_ptr) + k) % NREQ;
      if (!any_req && req[j[IW-1:0]]) begin
        any_req = 1'b1;
        win     = j[IW-1:0];
      end
    end
  end

  assign target = vol ? TGT_10L : TGT_5L;

  always_comb begin
    state_n  = state;
    reason_n = reason;
    rr_n     = rr_ptr;
    idx_n    = idx;
    vol_n    = vol;
    pulse_n  = pulse_cnt;
    pl_n     = pl_cnt;
    to_n     = to_cnt;
    litres_n = litres_out;
    grant_n  = grant;
    valve_n  = valve_sel;
    pump_n   = pump_on;
    done_n   = '0;
    fault_n  = '0;
    hit      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!tank_low && any_req) begin
          grant_n      = '0;
          grant_n[win] = 1'b1;
          valve_n      = '0;
          valve_n[win] = 1'b1;
          idx_n        = win;
          vol_n        = vol_sel[win];
          pulse_n      = '0;
          pl_n         = '0;
          to_n         = '0;
          litres_n     = '0;
          state_n      = PRIME;
        end
      end
      PRIME: begin
        pump_n  = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        if (flow_pulse) begin
          pulse_n = pulse_cnt + 1'b1;
          to_n    = '0;
          if (pl_cnt == PPL_M1) begin
            pl_n     = '0;
            litres_n = litres_out + 4'd1;
          end else begin
            pl_n = pl_cnt + 1'b1;
          end
          hit = ((pulse_cnt + 1'b1) == target);
        end else begin
          to_n = to_cnt + 1'b1;
        end
        // Exit priority: target reached, tank low, timeout, abort.
        if (hit) begin
          reason_n = EX_DONE;
          pump_n   = 1'b0;
          state_n  = CLOSE;
        end else if (tank_low || (!flow_pulse && to_cnt == TO_M1)) begin
          reason_n = EX_FAULT;
          pump_n   = 1'b0;
          state_n  = CLOSE;
        end else if (!req[idx]) begin
          reason_n = EX_ABORT;
          pump_n   = 1'b0;
          state_n  = CLOSE;
        end
      end
      CLOSE: begin
        grant_n      = '0;
        valve_n      = '0;
        done_n[idx]  = (reason == EX_DONE);
        fault_n[idx] = (reason == EX_FAULT);
        rr_n         = (idx == LAST) ? '0 : idx + 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      reason     <= EX_ABORT;
      rr_ptr     <= '0;
      idx        <= '0;
      vol        <= 1'b0;
      pulse_cnt  <= '0;
      pl_cnt     <= '0;
      to_cnt     <= '0;
      litres_out <= '0;
      grant      <= '0;
      valve_sel  <= '0;
      pump_on    <= 1'b0;
      done       <= '0;
      fault      <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      reason     <= reason_n;
      rr_ptr     <= rr_n;
      idx        <= idx_n;
      vol        <= vol_n;
      pulse_cnt  <= pulse_n;
      pl_cnt     <= pl_n;
      to_cnt     <= to_n;
      litres_out <= litres_n;
      grant      <= grant_n;
      valve_sel  <= valve_n;
      pump_on    <= pump_n;
      done       <= done_n;
      fault      <= fault_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_aqua_dispense_scheduler.sv
// Bench for aqua_dispense_scheduler: fixed vector table, directed dispense scenarios and
// randomized traffic, all checked against a litre/phase level reference model.
module tb_aqua_dispense_scheduler;

  localparam int N   = 4;
  localparam int PPL = 8;
  localparam int TO  = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, vol_sel, grant, valve_sel, done, fault;
  logic         flow_pulse, tank_low, pump_on, busy;
  logic [3:0]   litres_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aqua_dispense_scheduler #(
    .NREQ(N), .PULSES_PER_L(PPL), .CNT_W(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .vol_sel(vol_sel),
    .flow_pulse(flow_pulse), .tank_low(tank_low), .grant(grant),
    .valve_sel(valve_sel), .pump_on(pump_on), .done(done), .fault(fault),
    .busy(busy), .litres_out(litres_out)
  );

  // Reference model: phase 0 idle, 1 prime, 2 pumping, 3 draining.
  int         m_phase, m_owner, m_ptr, m_pulses, m_goal, m_silent, m_outcome;
  logic [3:0] m_done, m_fault;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_pulses = 0; m_goal = 0;
    m_silent = 0; m_outcome = 0; m_done = '0; m_fault = '0;
  endtask

  task automatic model_edge();
    m_done = '0;
    m_fault = '0;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (!tank_low && req != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_goal   = vol_sel[m_owner] ? 10 * PPL : 5 * PPL;
        m_pulses = 0;
        m_silent = 0;
        m_phase  = 1;
      end
      1: m_phase = 2;
      2: begin
        if (flow_pulse) begin
          m_pulses++;
          m_silent = 0;
        end else begin
          m_silent++;
        end
        m_outcome = 0;
        if (flow_pulse && m_pulses == m_goal) m_outcome = 1;
        else if (tank_low || m_silent >= TO)  m_outcome = 2;
        else if (!req[m_owner])               m_outcome = 3;
        if (m_outcome != 0) m_phase = 3;
      end
      default: begin
        if (m_outcome == 1) m_done[m_owner] = 1'b1;
        if (m_outcome == 2) m_fault[m_owner] = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_phase = 0;
      end
    endcase
  endtask

  function automatic logic [21:0] model_bundle();
    logic [3:0] g;
    g = '0;
    if (m_phase != 0) g[m_owner] = 1'b1;
    return {g, g, (m_phase == 2), m_done, m_fault, (m_phase != 0), 4'(m_pulses / PPL)};
  endfunction

  function automatic logic [21:0] dut_bundle();
    return {grant, valve_sel, pump_on, done, fault, busy, litres_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("model", 32'(dut_bundle()), 32'(model_bundle()));
  endtask

  typedef struct {
    logic [3:0] rq, vs;
    logic       fp, tl;
    logic [3:0] g;
    logic       p;
    logic [3:0] d, f;
    logic       b;
    logic [3:0] l;
  } vec_t;

  vec_t tbl[11];

  task automatic run_table();
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].rq; vol_sel = tbl[i].vs; flow_pulse = tbl[i].fp; tank_low = tbl[i].tl;
      step();
      check($sformatf("table[%0d]", i), 32'(dut_bundle()),
            32'({tbl[i].g, tbl[i].g, tbl[i].p, tbl[i].d, tbl[i].f, tbl[i].b, tbl[i].l}));
    end
    req = '0; flow_pulse = 1'b0; tank_low = 1'b0;
  endtask

  task automatic seq_single_5l();
    req = 4'b0001; vol_sel = 4'b0000;
    step();
    check("5l_grant", 32'(grant), 32'(4'b0001));
    step();
    check("5l_pump_on", 32'(pump_on), 1);
    for (int i = 0; i < 39; i++) begin
      flow_pulse = 1'b1; step(); flow_pulse = 1'b0; step();
    end
    check("5l_pump_still_on", 32'(pump_on), 1);
    flow_pulse = 1'b1; step(); flow_pulse = 1'b0;
    check("5l_pump_off_at_40", 32'(pump_on), 0);
    check("5l_litres", 32'(litres_out), 5);
    step();
    check("5l_done", 32'(done), 32'(4'b0001));
    req = '0;
    step();
  endtask

  task automatic seq_10l_gaps();
    req = 4'b0100; vol_sel = 4'b0100;
    step();
    check("10l_grant", 32'(grant), 32'(4'b0100));
    step();
    vol_sel = 4'b0000;
    for (int i = 0; i < 80; i++) begin
      flow_pulse = 1'b1; step(); flow_pulse = 1'b0;
      if (i < 79) repeat (9) step();
    end
    check("10l_pump_off", 32'(pump_on), 0);
    check("10l_litres", 32'(litres_out), 10);
    step();
    check("10l_done", 32'(done), 32'(4'b0100));
    check("10l_no_fault", 32'(fault), 0);
    req = '0;
    step();
  endtask

  task automatic seq_abort();
    req = 4'b1000; vol_sel = 4'b1000;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      flow_pulse = 1'b1; step(); flow_pulse = 1'b0;
    end
    req = '0;
    step();
    check("abort_pump_off", 32'(pump_on), 0);
    step();
    check("abort_no_done_fault", 32'({done, fault}), 0);
    req = 4'b1010;
    step();
    check("abort_ptr_wrapped", 32'(grant), 32'(4'b0010));
    req = '0;
    repeat (3) step();
  endtask

  task automatic seq_timeout();
    int c;
    req = 4'b0010; vol_sel = 4'b0000;
    step(); step();
    for (int i = 0; i < 12; i++) begin
      flow_pulse = 1'b1; step(); flow_pulse = 1'b0;
    end
    c = 0;
    while (fault == 0 && c < 60) begin
      step();
      c++;
    end
    check("timeout_latency", 32'(c), 32'(TO + 1));
    check("timeout_fault", 32'(fault), 32'(4'b0010));
    check("timeout_no_done", 32'(done), 0);
    check("timeout_litres", 32'(litres_out), 1);
    req = '0;
    step();
  endtask

  task automatic seq_reset_mid_run();
    req = 4'b1000; vol_sel = 4'b0000;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      flow_pulse = 1'b1; step(); flow_pulse = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("async_reset", 32'(dut_bundle()), 0);
    model_reset();
    req = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic seq_round_robin();
    logic [3:0] order [4];
    int w;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000; order[3] = 4'b0001;
    req = 4'b1011; vol_sel = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      while (grant == 0 && w < 10) begin
        step();
        w++;
      end
      check($sformatf("rr_grant[%0d]", t), 32'(grant), 32'(order[t]));
      step();
      repeat (40) begin
        flow_pulse = 1'b1; step(); flow_pulse = 1'b0; step();
      end
      check($sformatf("rr_done[%0d]", t), 32'(done), 32'(order[t]));
    end
    req = '0;
    step();
  endtask

  task automatic seq_random();
    int fp_pct;
    fp_pct = 60;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0)
        case ((cyc / 500) % 3)
          0:       fp_pct = 60;
          1:       fp_pct = 25;
          default: fp_pct = 4;
        endcase
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 39) == 0) req[b] = ~req[b];
      vol_sel    = 4'($urandom);
      flow_pulse = ($urandom_range(0, 99) < fp_pct);
      tank_low   = ($urandom_range(0, 199) < 3);
      step();
    end
    req = '0; flow_pulse = 1'b0; tank_low = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    //        req      vol      fp    tl    grant    pump  done  fault    busy  litres
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0, 4'b0000, 1'b0, 4'd0};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0, 4'b0000, 1'b1, 4'd0};
    tbl[2]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0, 4'b0000, 1'b1, 4'd0};
    tbl[3]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0, 4'b0000, 1'b1, 4'd0};
    tbl[4]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 4'b0, 4'b0000, 1'b1, 4'd0};
    tbl[5]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0, 4'b0001, 1'b0, 4'd0};
    tbl[6]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0, 4'b0000, 1'b0, 4'd0};
    tbl[7]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0, 4'b0000, 1'b1, 4'd0};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0, 4'b0000, 1'b1, 4'd0};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0, 4'b0000, 1'b1, 4'd0};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0, 4'b0000, 1'b0, 4'd0};

    reset = 1'b1; req = '0; vol_sel = '0; flow_pulse = 1'b0; tank_low = 1'b0;
    model_reset();
    repeat (2) step();
    check("reset_state", 32'(dut_bundle()), 0);
    reset = 1'b0;

    run_table();
    seq_single_5l();
    seq_10l_gaps();
    seq_abort();
    seq_timeout();
    seq_reset_mid_run();
    seq_round_robin();
    seq_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aqua_dispense_scheduler.md
Name: aqua_dispense_scheduler

Overview:
- Shares one pump and manifold between NREQ vending front-ends (smart_aqua-style kiosks). Each kiosk has completed payment for a 5 L or 10 L order.
- Arbitrates requests round-robin, opens the winner's valve, and runs the pump until the flow-meter pulse count reaches the ordered volume.
- Reports completion, fault or abort back to the requesting kiosk.
- Sits between the kiosk FSMs and the pump/valve drivers.

Parameters:
- NREQ, 4, number of kiosks sharing the pump (2..8).
- PULSES_PER_L, 8, flow-meter pulses per litre.
- CNT_W, 8, pulse counter width; must hold 10*PULSES_PER_L.
- TIMEOUT, 1023, RUN cycles without a flow_pulse before a fault is declared.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-kiosk dispense request; level, held until done/fault.
- vol_sel  in  NREQ  per-kiosk volume: 0 = 5 L, 1 = 10 L; sampled at grant.
- flow_pulse  in  1  single-cycle, already-synchronised flow-meter pulse.
- tank_low  in  1  level: reservoir below minimum.
- grant  out  NREQ  one-hot owner of the pump; all zero when idle.
- valve_sel  out  NREQ  one-hot valve open command.
- pump_on  out  1  pump motor enable.
- done  out  NREQ  one-cycle pulse: ordered volume delivered.
- fault  out  NREQ  one-cycle pulse: timeout or tank_low during dispense.
- busy  out  1  high in any state other than IDLE.
- litres_out  out  4  whole litres delivered in the current/last dispense.

Behaviour:
- Reset (async): state=IDLE, RR pointer=0, grant/valve_sel/done/fault=0, pump_on=0, busy=0, litres_out=0, all counters=0.
- All outputs are registered.
- FSM states: IDLE, PRIME, RUN, CLOSE.
- IDLE:
  - If tank_low=0 and any req bit is high, pick the first requester at or after the RR pointer, wrapping.
  - Next edge: grant[i]=valve_sel[i]=1, latch vol_sel[i], clear pulse/litre/timeout counters, litres_out=0, state→PRIME.
  - If tank_low=1, no grant is issued; requests wait.
- PRIME: exactly one cycle, valve open, pump off. Next edge: pump_on=1, state→RUN.
- Latency: req sampled high at edge N gives grant at N, pump_on at N+1.
- RUN:
  - Each flow_pulse increments the pulse counter and clears the timeout counter.
  - Every PULSES_PER_L pulses, litres_out increments.
  - Target is 5*PULSES_PER_L (vol_sel=0) or 10*PULSES_PER_L (vol_sel=1).
  - The edge on which the count reaches target: pump_on=0, state→CLOSE, exit reason = DONE.
  - Timeout counter reaches TIMEOUT with no pulse: pump_on=0, state→CLOSE, exit reason = FAULT.
  - tank_low=1 at any RUN edge: same as timeout, exit reason = FAULT.
  - req[i] deasserted at a RUN edge: pump_on=0, state→CLOSE, exit reason = ABORT.
  - Priority when events coincide on one edge: target reached > tank_low > timeout > abort. The final pulse still counts.
- CLOSE: one cycle, valve still open (line drain), pump off. Next edge:
  - grant=valve_sel=0, state→IDLE.
  - done[i]=1 if DONE; fault[i]=1 if FAULT; neither if ABORT.
  - RR pointer = i+1 mod NREQ.
- done/fault pulses coincide with the first IDLE cycle. A new grant can issue on the following edge, so the minimum gap between dispenses is 1 idle cycle.
- flow_pulse outside RUN is ignored.
- litres_out holds its value until the next grant.
- Request changes for non-granted kiosks during a dispense have no effect until IDLE.
- vol_sel changes after grant are ignored.
- The same kiosk may win again only after all other active requesters have been served.
- grant and valve_sel are never multi-hot. pump_on=1 implies exactly one valve_sel bit is set.

Test Plan:
- Single 5 L: req[0]=1, vol_sel[0]=0, 40 flow pulses → grant[0] next edge, pump_on one cycle later, pump_on=0 on the 40th pulse, done[0] after CLOSE, litres_out=5.
- 10 L with idle gaps: req[2]=1, vol_sel[2]=1, 80 pulses spaced 10 cycles apart → done[2], litres_out=10, no fault.
- Round-robin: req=4'b1011 held, each dispense completed → grant order 0,1,3,0; no kiosk served twice while another waits.
- Timeout (bench TIMEOUT=20): grant kiosk 1, 12 pulses then silence → fault[1] 20 cycles after the last pulse plus CLOSE, no done, litres_out=1.
- tank_low: asserted in IDLE with req[0]=1 → no grant. Asserted mid-RUN → pump_on=0 next edge, fault[0]. Deasserted → arbitration resumes.
- Abort and reset: req[3] dropped mid-RUN → pump off, no done/fault, pointer advances to 0. Reset asserted mid-RUN → all outputs 0 immediately.
